// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline with load-use stall and taken-branch squash of the ID instruction.
// Optional build macro CTRL_PIPE_PERF_EN adds 32-bit stall/flush event counters.
module ctrl_pipe #(
    parameter int RD_W     = 5,
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic                id_reg_write,
    input  logic                id_alu_src,
    input  logic                id_mem_write,
    input  logic                id_mem_read,
    input  logic                id_mem_to_reg,
    input  logic                id_pc_src,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [RD_W-1:0]     id_rd,
    input  logic [RD_W-1:0]     id_rs1,
    input  logic [RD_W-1:0]     id_rs2,
    input  logic                id_uses_rs2,
    input  logic                ex_branch_taken,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_alu_src,
    output logic                ex_mem_write,
    output logic                ex_mem_read,
    output logic                ex_mem_to_reg,
    output logic                ex_pc_src,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [RD_W-1:0]     ex_rd,
    output logic                mem_valid,
    output logic                mem_reg_write,
    output logic                mem_mem_write,
    output logic                mem_mem_read,
    output logic                mem_mem_to_reg,
    output logic [RD_W-1:0]     mem_rd,
    output logic                wb_valid,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [RD_W-1:0]     wb_rd,
    output logic                stall,
    output logic                flush,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_flush_cnt
);

    logic                r_ex_valid, r_ex_reg_write, r_ex_alu_src, r_ex_mem_write;
    logic                r_ex_mem_read, r_ex_mem_to_reg, r_ex_pc_src;
    logic [ALU_OP_W-1:0] r_ex_alu_op;
    logic [RD_W-1:0]     r_ex_rd;
    logic                r_mem_valid, r_mem_reg_write, r_mem_mem_write, r_mem_mem_read, r_mem_mem_to_reg;
    logic [RD_W-1:0]     r_mem_rd;
    logic                r_wb_valid, r_wb_reg_write, r_wb_mem_to_reg;
    logic [RD_W-1:0]     r_wb_rd;

    logic w_br, w_hazard, w_rs_match, w_ex_take;

    assign w_br       = r_ex_valid & r_ex_pc_src & ex_branch_taken;
    assign w_rs_match = (r_ex_rd == id_rs1) | (id_uses_rs2 & (r_ex_rd == id_rs2));
    assign w_hazard   = id_valid & r_ex_valid & r_ex_mem_read & (r_ex_rd != '0) & w_rs_match;
    // A taken branch overrides the hazard: the dependent instruction is discarded anyway.
    assign w_ex_take  = id_valid & ~w_br & ~w_hazard;

    assign flush    = w_br;
    assign stall    = ~w_br & w_hazard;
    assign id_ready = w_br | ~w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid      <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_alu_src    <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
            r_ex_pc_src     <= 1'b0;
            r_ex_alu_op     <= '0;
            r_ex_rd         <= '0;
        end else begin
            r_ex_valid      <= w_ex_take;
            r_ex_reg_write  <= w_ex_take & id_reg_write & (id_rd != '0);
            r_ex_alu_src    <= w_ex_take & id_alu_src;
            r_ex_mem_write  <= w_ex_take & id_mem_write;
            r_ex_mem_read   <= w_ex_take & id_mem_read;
            r_ex_mem_to_reg <= w_ex_take & id_mem_to_reg;
            r_ex_pc_src     <= w_ex_take & id_pc_src;
            r_ex_alu_op     <= w_ex_take ? id_alu_op : '0;
            r_ex_rd         <= w_ex_take ? id_rd : '0;
        end
    end

    // Bubbles carry all-zero fields, so MEM and WB can copy unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid      <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_mem_read   <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_rd         <= '0;
            r_wb_valid       <= 1'b0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_rd          <= '0;
        end else begin
            r_mem_valid      <= r_ex_valid;
            r_mem_reg_write  <= r_ex_reg_write;
            r_mem_mem_write  <= r_ex_mem_write;
            r_mem_mem_read   <= r_ex_mem_read;
            r_mem_mem_to_reg <= r_ex_mem_to_reg;
            r_mem_rd         <= r_ex_rd;
            r_wb_valid       <= r_mem_valid;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_rd          <= r_mem_rd;
        end
    end

    assign ex_valid       = r_ex_valid;
    assign ex_reg_write   = r_ex_reg_write;
    assign ex_alu_src     = r_ex_alu_src;
    assign ex_mem_write   = r_ex_mem_write;
    assign ex_mem_read    = r_ex_mem_read;
    assign ex_mem_to_reg  = r_ex_mem_to_reg;
    assign ex_pc_src      = r_ex_pc_src;
    assign ex_alu_op      = r_ex_alu_op;
    assign ex_rd          = r_ex_rd;
    assign mem_valid      = r_mem_valid;
    assign mem_reg_write  = r_mem_reg_write;
    assign mem_mem_write  = r_mem_mem_write;
    assign mem_mem_read   = r_mem_mem_read;
    assign mem_mem_to_reg = r_mem_mem_to_reg;
    assign mem_rd         = r_mem_rd;
    assign wb_valid       = r_wb_valid;
    assign wb_reg_write   = r_wb_reg_write;
    assign wb_mem_to_reg  = r_wb_mem_to_reg;
    assign wb_rd          = r_wb_rd;

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + {31'd0, stall};
            r_flush_cnt <= r_flush_cnt + {31'd0, flush};
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule
